// File: rtl/frame_write_burst_ctrl_if.sv
// Write-burst handshake between a channel sequencer (master) and the DDR3
// write arbiter port (slave).
interface frame_write_burst_ctrl_if #(
  parameter int ADDR_BITS  = 23,
  parameter int BURST_BITS = 10
);
  logic                  wr_burst_req;
  logic [BURST_BITS-1:0] wr_burst_len;
  logic [ADDR_BITS-1:0]  wr_burst_addr;
  logic                  wr_burst_data_req;
  logic                  wr_burst_finish;

  modport master (
    output wr_burst_req, wr_burst_len, wr_burst_addr,
    input  wr_burst_data_req, wr_burst_finish
  );

  modport slave (
    input  wr_burst_req, wr_burst_len, wr_burst_addr,
    output wr_burst_data_req, wr_burst_finish
  );
endinterface

// File: rtl/frame_write_burst_ctrl.sv
// Slices each frame in the channel write FIFO into arbiter bursts and rotates
// the frame-buffer index around the buffer currently being displayed.
//
// state | meaning
// IDLE  | no frame in progress
// WAIT  | frame active, waiting for enough FIFO words for the next burst
// BURST | burst requested/granted, draining FIFO on data_req
// NEXT  | one-cycle bookkeeping after finish; handles a pending frame_start
module frame_write_burst_ctrl #(
  parameter int                   ADDR_BITS    = 23,
  parameter int                   BURST_BITS   = 10,
  parameter int                   LEVEL_BITS   = 11,
  parameter int                   MAX_BURST    = 128,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_BITS-1:0] FRAME_STRIDE = 23'h080000,
  parameter int                   NUM_FRAMES   = 3
) (
  input  logic                  mem_clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [ADDR_BITS-1:0]  frame_words,
  input  logic [LEVEL_BITS-1:0] fifo_level,
  output logic                  fifo_rd_en,
  input  logic [1:0]            rd_frame_idx,
  frame_write_burst_ctrl_if.master bus,
  output logic [1:0]            wr_frame_idx,
  output logic                  frame_done,
  output logic                  frame_drop
);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, NEXT} state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_FRAMES - 1);

  state_t                state, state_n;
  logic [1:0]            cur_idx, cur_idx_n, wr_frame_idx_n, idx_inc, idx_skip;
  logic [ADDR_BITS-1:0]  offset, offset_n, remaining, remaining_n;
  logic [ADDR_BITS-1:0]  shadow, shadow_n, rem_after, new_words, addr, addr_n;
  logic [BURST_BITS-1:0] len, len_n, len_c;
  logic                  pending, pending_n, new_pending;
  logic                  req, req_n, done_n, drop_n;

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state        <= IDLE;
      cur_idx      <= '0;
      offset       <= '0;
      remaining    <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
      req          <= 1'b0;
      len          <= '0;
      addr         <= '0;
      wr_frame_idx <= '0;
      frame_done   <= 1'b0;
      frame_drop   <= 1'b0;
    end else begin
      state        <= state_n;
      cur_idx      <= cur_idx_n;
      offset       <= offset_n;
      remaining    <= remaining_n;
      shadow       <= shadow_n;
      pending      <= pending_n;
      req          <= req_n;
      len          <= len_n;
      addr         <= addr_n;
      wr_frame_idx <= wr_frame_idx_n;
      frame_done   <= done_n;
      frame_drop   <= drop_n;
    end
  end

  always_comb begin
    state_n        = state;
    cur_idx_n      = cur_idx;
    offset_n       = offset;
    remaining_n    = remaining;
    shadow_n       = shadow;
    pending_n      = pending;
    req_n          = req;
    len_n          = len;
    addr_n         = addr;
    wr_frame_idx_n = wr_frame_idx;
    done_n         = 1'b0;
    drop_n         = 1'b0;

    len_c = (remaining < ADDR_BITS'(MAX_BURST)) ? BURST_BITS'(remaining)
                                                 : BURST_BITS'(MAX_BURST);
    rem_after = remaining - ADDR_BITS'(len);
    // A frame_start landing in NEXT itself is treated as already pending.
    new_pending = pending | frame_start;
    new_words   = frame_start ? frame_words : shadow;
    idx_inc  = (cur_idx == LAST_IDX) ? 2'd0 : cur_idx + 2'd1;
    idx_skip = (idx_inc != rd_frame_idx) ? idx_inc :
               (idx_inc == LAST_IDX) ? 2'd0 : idx_inc + 2'd1;

    case (state)
      IDLE: begin
        if (frame_start && frame_words != '0) begin
          remaining_n = frame_words;
          offset_n    = '0;
          state_n     = WAIT;
        end
      end
      WAIT: begin
        if (frame_start) begin
          drop_n      = 1'b1;
          remaining_n = frame_words;
          offset_n    = '0;
          if (frame_words == '0) state_n = IDLE;
        end else if (32'(fifo_level) >= 32'(len_c)) begin
          req_n   = 1'b1;
          len_n   = len_c;
          addr_n  = BASE_ADDR + ADDR_BITS'(cur_idx) * FRAME_STRIDE + offset;
          state_n = BURST;
        end
      end
      BURST: begin
        if (frame_start) begin
          pending_n = 1'b1;
          shadow_n  = frame_words;
        end
        if (bus.wr_burst_finish) begin
          req_n   = 1'b0;
          state_n = NEXT;
        end
      end
      NEXT: begin
        offset_n    = offset + ADDR_BITS'(len);
        remaining_n = rem_after;
        pending_n   = 1'b0;
        shadow_n    = new_words;
        if (rem_after == '0) begin
          done_n         = 1'b1;
          wr_frame_idx_n = cur_idx;
          cur_idx_n      = idx_skip;
        end else if (new_pending) begin
          drop_n = 1'b1;
        end
        if (new_pending) begin
          remaining_n = new_words;
          offset_n    = '0;
          state_n     = (new_words == '0) ? IDLE : WAIT;
        end else begin
          state_n = (rem_after == '0) ? IDLE : WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign fifo_rd_en        = bus.wr_burst_data_req && (state == BURST);
  assign bus.wr_burst_req  = req;
  assign bus.wr_burst_len  = len;
  assign bus.wr_burst_addr = addr;

endmodule

// File: tb/tb_frame_write_burst_ctrl.sv
// Directed bench: expected bursts are queued when frames are started and
// checked as the DUT raises each request toward the arbiter model.
module tb_frame_write_burst_ctrl;

  typedef struct {
    int len;
    int addr;
  } burst_t;

  logic        mem_clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [22:0] frame_words = '0;
  logic [10:0] fifo_level = 11'd511;
  logic        fifo_rd_en;
  logic [1:0]  rd_frame_idx = 2'd0;
  logic [1:0]  wr_frame_idx;
  logic        frame_done;
  logic        frame_drop;

  int     vectors = 0;
  int     miscompares = 0;
  int     rd_cnt = 0;
  burst_t exp_q[$];

  frame_write_burst_ctrl_if #(.ADDR_BITS(23), .BURST_BITS(10)) bus ();

  frame_write_burst_ctrl dut (
    .mem_clk      (mem_clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .frame_words  (frame_words),
    .fifo_level   (fifo_level),
    .fifo_rd_en   (fifo_rd_en),
    .rd_frame_idx (rd_frame_idx),
    .bus          (bus),
    .wr_frame_idx (wr_frame_idx),
    .frame_done   (frame_done),
    .frame_drop   (frame_drop)
  );

  always #5 mem_clk = ~mem_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference slicing of a frame into bursts of at most 128 words.
  task automatic push_frame(input int words, input int idx);
    int off = 0;
    int l;
    while (words > 0) begin
      l = (words < 128) ? words : 128;
      exp_q.push_back('{len: l, addr: (idx * 32'h080000 + off) & 32'h7fffff});
      off += l;
      words -= l;
    end
  endtask

  task automatic start_frame(input int words);
    frame_start = 1'b1;
    frame_words = 23'(words);
    tick();
    frame_start = 1'b0;
  endtask

  // Arbiter model: grant after two idle cycles, stream len words, pulse finish.
  // fs_at >= 0 injects a frame_start at that cycle of the burst.
  task automatic serve(input int fs_at, input int fs_words);
    burst_t e;
    int n = 0;
    while (bus.wr_burst_req !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(bus.wr_burst_req), 32'd1);
    if (bus.wr_burst_req !== 1'b1) return;
    if (exp_q.size() == 0) begin
      chk("queue_has_burst", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("burst_len", 32'(bus.wr_burst_len), 32'(e.len));
    chk("burst_addr", 32'(bus.wr_burst_addr), 32'(e.addr));
    for (int i = 0; i < e.len + 2; i++) begin
      bus.wr_burst_data_req = (i >= 2);
      frame_start = (i == fs_at);
      if (i == fs_at) frame_words = 23'(fs_words);
      @(negedge mem_clk);
      chk("fifo_rd_en", 32'(fifo_rd_en), 32'(i >= 2));
      rd_cnt += int'(fifo_rd_en);
      if (fs_at >= 0) begin
        chk("hold_req", 32'(bus.wr_burst_req), 32'd1);
        chk("hold_len", 32'(bus.wr_burst_len), 32'(e.len));
        chk("hold_addr", 32'(bus.wr_burst_addr), 32'(e.addr));
      end
      tick();
    end
    bus.wr_burst_data_req = 1'b0;
    frame_start = 1'b0;
    bus.wr_burst_finish = 1'b1;
    tick();
    bus.wr_burst_finish = 1'b0;
    chk("req_after_finish", 32'(bus.wr_burst_req), 32'd0);
  endtask

  initial begin
    bus.wr_burst_data_req = 1'b0;
    bus.wr_burst_finish   = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_req", 32'(bus.wr_burst_req), 32'd0);
    chk("rst_len", 32'(bus.wr_burst_len), 32'd0);
    chk("rst_addr", 32'(bus.wr_burst_addr), 32'd0);
    chk("rst_frame_idx", 32'(wr_frame_idx), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_drop", 32'(frame_drop), 32'd0);
    @(negedge mem_clk);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 300-word frame into buffer 0
    rd_cnt = 0;
    start_frame(300);
    push_frame(300, 0);
    serve(-1, 0);
    serve(-1, 0);
    serve(-1, 0);
    tick();
    chk("t1_done", 32'(frame_done), 32'd1);
    chk("t1_frame_idx", 32'(wr_frame_idx), 32'd0);
    chk("t1_rd_cycles", 32'(rd_cnt), 32'd300);
    tick();
    chk("t1_done_pulse", 32'(frame_done), 32'd0);

    // FIFO starvation holds off the request; buffer 1
    fifo_level = 11'd100;
    start_frame(200);
    push_frame(200, 1);
    repeat (5) tick();
    chk("t2_req_starved", 32'(bus.wr_burst_req), 32'd0);
    bus.wr_burst_data_req = 1'b1;
    @(negedge mem_clk);
    chk("t2_rd_en_outside_burst", 32'(fifo_rd_en), 32'd0);
    tick();
    bus.wr_burst_data_req = 1'b0;
    fifo_level = 11'd128;
    tick();
    chk("t2_req_next_cycle", 32'(bus.wr_burst_req), 32'd1);
    chk("t2_len", 32'(bus.wr_burst_len), 32'd128);
    serve(-1, 0);
    serve(-1, 0);
    fifo_level = 11'd511;
    tick();
    chk("t2_done", 32'(frame_done), 32'd1);
    chk("t2_frame_idx", 32'(wr_frame_idx), 32'd1);

    // Buffer 2 done with reader on 0: next index skips 0 and lands on 1
    start_frame(64);
    push_frame(64, 2);
    serve(-1, 0);
    tick();
    chk("t3a_frame_idx", 32'(wr_frame_idx), 32'd2);
    // Buffer 1 done with reader on 2: next index skips 2 and lands on 0
    rd_frame_idx = 2'd2;
    start_frame(64);
    push_frame(64, 1);
    serve(-1, 0);
    tick();
    chk("t3_done", 32'(frame_done), 32'd1);
    chk("t3_frame_idx", 32'(wr_frame_idx), 32'd1);

    // frame_start while waiting for FIFO: drop and restart buffer 0 at offset 0
    start_frame(300);
    push_frame(300, 0);
    serve(-1, 0);
    fifo_level = 11'd0;
    tick();
    frame_start = 1'b1;
    frame_words = 23'd200;
    tick();
    frame_start = 1'b0;
    chk("t4_drop", 32'(frame_drop), 32'd1);
    chk("t4_frame_idx_kept", 32'(wr_frame_idx), 32'd1);
    exp_q.delete();
    push_frame(200, 0);
    fifo_level = 11'd511;
    tick();
    chk("t4_drop_pulse", 32'(frame_drop), 32'd0);
    serve(-1, 0);
    serve(-1, 0);
    tick();
    chk("t4_done", 32'(frame_done), 32'd1);
    chk("t4_frame_idx", 32'(wr_frame_idx), 32'd0);

    // frame_start during a mid-frame burst: burst completes, then drop/restart
    start_frame(300);
    push_frame(300, 1);
    serve(-1, 0);
    serve(3, 100);
    tick();
    chk("t5_drop", 32'(frame_drop), 32'd1);
    chk("t5_no_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    push_frame(100, 1);
    // frame_start during the final burst: frame completes, new one follows
    serve(5, 64);
    tick();
    chk("t5_done", 32'(frame_done), 32'd1);
    chk("t5_no_drop", 32'(frame_drop), 32'd0);
    chk("t5_frame_idx", 32'(wr_frame_idx), 32'd1);
    exp_q.delete();
    push_frame(64, 0);
    serve(-1, 0);
    tick();
    chk("t5_new_done", 32'(frame_done), 32'd1);
    chk("t5_new_frame_idx", 32'(wr_frame_idx), 32'd0);

    // Reset in the middle of a burst
    start_frame(300);
    begin
      int n = 0;
      while (bus.wr_burst_req !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
    end
    chk("t6_req_before_rst", 32'(bus.wr_burst_req), 32'd1);
    chk("t6_addr_before_rst", 32'(bus.wr_burst_addr), 32'h080000);
    bus.wr_burst_data_req = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("t6_req_after_rst", 32'(bus.wr_burst_req), 32'd0);
    @(negedge mem_clk);
    chk("t6_rd_en_after_rst", 32'(fifo_rd_en), 32'd0);
    tick();
    rst = 1'b0;
    bus.wr_burst_data_req = 1'b0;
    tick();
    exp_q.delete();
    start_frame(64);
    push_frame(64, 0);
    serve(-1, 0);
    tick();
    chk("t6_done", 32'(frame_done), 32'd1);
    chk("t6_frame_idx", 32'(wr_frame_idx), 32'd0);

    // Zero-length frame_start in IDLE is ignored
    tick();
    start_frame(0);
    repeat (4) tick();
    chk("t7_zero_req", 32'(bus.wr_burst_req), 32'd0);
    chk("t7_zero_drop", 32'(frame_drop), 32'd0);
    chk("t7_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_write_burst_ctrl.md
Name: frame_write_burst_ctrl

Overview:
Per-channel write sequencer that sits in front of one channel port of the 4-channel DDR3 write arbiter. It slices each video frame held in the channel's write FIFO into bursts of at most MAX_BURST words. For each burst it issues req/len/addr toward the arbiter, drains the FIFO while data is requested, and rotates the frame-buffer index so the writer never lands on the buffer the reader is displaying.

Parameters:
ADDR_BITS, 23, word-address width toward the arbiter
BURST_BITS, 10, burst-length width
LEVEL_BITS, 11, FIFO fill-level width
MAX_BURST, 128, maximum words per burst (1..2^BURST_BITS-1)
BASE_ADDR, 0, word address of frame buffer 0
FRAME_STRIDE, 23'h080000, word distance between frame buffers
NUM_FRAMES, 3, buffers in rotation (3..4)

Ports:
mem_clk  in  1  memory-domain clock
rst  in  1  synchronous active-high reset
frame_start  in  1  one-cycle frame-start pulse, already in mem_clk domain
frame_words  in  ADDR_BITS  words in the coming frame; sampled only when frame_start is high
fifo_level  in  LEVEL_BITS  words currently readable in the channel write FIFO
fifo_rd_en  out  1  FIFO read strobe
rd_frame_idx  in  2  buffer index the read side is displaying
wr_burst_req  out  1  to arbiter chN_wr_burst_req
wr_burst_len  out  BURST_BITS  to arbiter chN_wr_burst_len
wr_burst_addr  out  ADDR_BITS  to arbiter chN_wr_burst_addr
wr_burst_data_req  in  1  from arbiter chN_wr_burst_data_req
wr_burst_finish  in  1  from arbiter chN_wr_burst_finish (one-cycle pulse)
wr_frame_idx  out  2  index of the last fully written buffer
frame_done  out  1  one-cycle pulse when a frame completes
frame_drop  out  1  one-cycle pulse when an incomplete frame is abandoned

Behaviour:
- Reset values: all outputs 0; cur_idx=0; offset=0; remaining=0; pending=0; state IDLE. Reset is honoured in any state, including mid-burst. The arbiter must be reset in the same cycle.
- States: IDLE, WAIT, BURST, NEXT.
- IDLE:
  - frame_start with frame_words!=0 → latch remaining=frame_words, offset=0, go to WAIT.
  - frame_words==0 → pulse ignored, no frame_drop.
- WAIT:
  - len_c = min(remaining, MAX_BURST).
  - When fifo_level >= len_c, register wr_burst_len=len_c and wr_burst_addr=(BASE_ADDR + cur_idx*FRAME_STRIDE + offset) mod 2^ADDR_BITS, set wr_burst_req=1, go to BURST. Outputs are registered, so req asserts the cycle after the condition is met.
- BURST:
  - wr_burst_req, wr_burst_len and wr_burst_addr are held stable.
  - fifo_rd_en = wr_burst_data_req && state==BURST (combinational, zero latency; FIFO is show-ahead).
  - On wr_burst_finish: wr_burst_req←0 in the same registered update, go to NEXT. req must be low before the arbiter's next CHECK of this channel so a stale len is never re-granted.
- NEXT (one cycle): offset += wr_burst_len; remaining -= wr_burst_len.
  - If remaining becomes 0:
    - Pulse frame_done; wr_frame_idx←cur_idx.
    - cur_idx←(cur_idx+1) mod NUM_FRAMES; if that equals rd_frame_idx, advance one more (mod NUM_FRAMES).
    - If pending: clear it, start the new frame (WAIT, offset 0) with no frame_drop; else go to IDLE.
  - If remaining != 0:
    - If pending: pulse frame_drop, clear pending, restart the current buffer at offset 0 with the latched new length, go to WAIT.
    - Else go to WAIT.
- frame_start in WAIT: pulse frame_drop next cycle, reload remaining from frame_words, offset=0, same cur_idx, stay in WAIT. If frame_words==0 → go to IDLE after the drop.
- frame_start in BURST or NEXT: never aborts a granted burst. Latch pending=1 and capture frame_words into a shadow register; the pending frame is handled in NEXT. A second frame_start while pending overwrites the shadow.
- wr_burst_data_req outside BURST is ignored (fifo_rd_en stays 0).

Test Plan:
1. rst, frame_words=300, fifo_level=511 steady, arbiter model → three bursts: len 128 @0x000000, 128 @0x000080, 44 @0x000100. frame_done pulses once, wr_frame_idx=0, cur_idx=1, exactly 300 fifo_rd_en cycles.
2. Frame with fifo_level stuck at 100, MAX_BURST=128 → wr_burst_req stays 0. Raise level to 128 → req the following cycle with len=128.
3. cur_idx=1, rd_frame_idx=2, complete a 64-word frame → frame_done, wr_frame_idx=1, next burst address base 0x000000 (idx 0, buffer 2 skipped).
4. frame_start during WAIT after one of three bursts → frame_drop pulse. Next burst address returns to offset 0 of the same buffer; wr_frame_idx unchanged.
5. frame_start while wr_burst_req is high (second burst) → req/len/addr stay stable until finish. Then frame_drop and restart at offset 0. Repeat with frame_start during the final burst → frame_done, no frame_drop, new frame starts in the next buffer.
6. Assert rst mid-BURST → next cycle wr_burst_req=0, fifo_rd_en=0, state IDLE. A subsequent frame_start writes buffer 0 at 0x000000.
